// File: rtl/rom_uart_streamer_pkg.sv
// rtl/rom_uart_streamer_pkg.sv - shared state encoding and width helpers for rom_uart_streamer
package rom_uart_streamer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_SEND  = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    localparam int DEF_ADDR_W = 10;

    // Byte counts run 0..2^ADDR_W inclusive, hence one extra bit.
    localparam int CNT_EXTRA_BITS = 1;

    function automatic int cnt_width(input int addr_w);
        return addr_w + CNT_EXTRA_BITS;
    endfunction

endpackage

// File: rtl/rom_uart_streamer_gap_cnt.sv
// rtl/rom_uart_streamer_gap_cnt.sv - loadable down-counter with zero flag, shared by the ROM-latency and gap waits
module streamer_gap_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output logic         o_zero
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/rom_uart_streamer.sv
// rtl/rom_uart_streamer.sv - streams a (base, len) window of a synchronous ROM to a UART over valid/ready
module rom_uart_streamer
    import rom_uart_streamer_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = 8,
    parameter int ROM_LAT = 1,
    parameter int GAP_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic              i_abort,
    input  logic              i_loop,
    input  logic [ADDR_W-1:0] i_base,
    input  logic [ADDR_W:0]   i_len,
    input  logic [GAP_W-1:0]  i_gap,
    output logic [ADDR_W-1:0] o_rom_addr,
    input  logic [DATA_W-1:0] i_rom_q,
    output logic [DATA_W-1:0] o_data,
    output logic              o_vld,
    input  logic              i_rdy,
    output logic              o_busy,
    output logic              o_done
);

    localparam int CNT_W = cnt_width(ADDR_W);
    localparam int LAT_W = $clog2(ROM_LAT + 1);
    localparam int TMR_W = (GAP_W > LAT_W) ? GAP_W : LAT_W;
    localparam logic [TMR_W-1:0] LAT_LOAD = TMR_W'(ROM_LAT);

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_base;
    logic [ADDR_W-1:0] r_rom_addr;
    logic [ADDR_W-1:0] r_next_addr;
    logic [CNT_W-1:0]  r_len;
    logic [CNT_W-1:0]  r_remain;
    logic [GAP_W-1:0]  r_gap;
    logic              r_loop;
    logic              r_done;
    logic [DATA_W-1:0] r_data;

    logic              w_tmr_zero;
    logic              w_tmr_load;
    logic [TMR_W-1:0]  w_tmr_val;
    logic              w_launch;
    logic              w_xfer;
    logic              w_last;
    logic              w_finish;
    logic              w_capture;
    logic              w_issue;
    logic              w_empty_start;
    logic [ADDR_W-1:0] w_adv_addr;
    logic [ADDR_W-1:0] w_issue_addr;

    assign w_launch     = (r_state == ST_IDLE) && i_start && (i_len != '0);
    assign w_xfer       = (r_state == ST_SEND) && i_rdy;
    assign w_last       = (r_remain == CNT_W'(1));
    assign w_adv_addr   = w_last ? r_base : r_rom_addr + 1'b1;
    // With no gap the next address goes out straight from SEND; otherwise it waits in r_next_addr.
    assign w_issue_addr = (r_state == ST_SEND) ? w_adv_addr : r_next_addr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (i_start && (i_len != '0)) w_next = ST_FETCH;
            end
            ST_FETCH: begin
                if (i_abort)         w_next = ST_IDLE;
                else if (w_tmr_zero) w_next = ST_SEND;
            end
            ST_SEND: begin
                if (i_abort) begin
                    w_next = ST_IDLE;
                end else if (i_rdy) begin
                    if (w_last && !r_loop) w_next = ST_IDLE;
                    else if (r_gap == '0)  w_next = ST_FETCH;
                    else                   w_next = ST_GAP;
                end
            end
            ST_GAP: begin
                if (i_abort)         w_next = ST_IDLE;
                else if (w_tmr_zero) w_next = ST_FETCH;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_tmr_load    = 1'b0;
        w_tmr_val     = LAT_LOAD;
        w_capture     = 1'b0;
        w_issue       = 1'b0;
        w_finish      = 1'b0;
        w_empty_start = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_tmr_load    = w_launch;
                w_empty_start = i_start && (i_len == '0);
            end
            ST_FETCH: begin
                w_capture = w_tmr_zero && !i_abort;
            end
            ST_SEND: begin
                if (i_rdy && !i_abort) begin
                    if (w_last && !r_loop) begin
                        w_finish = 1'b1;
                    end else if (r_gap == '0) begin
                        w_issue    = 1'b1;
                        w_tmr_load = 1'b1;
                    end else begin
                        w_tmr_load = 1'b1;
                        w_tmr_val  = TMR_W'(r_gap) - 1'b1;
                    end
                end
            end
            ST_GAP: begin
                if (w_tmr_zero && !i_abort) begin
                    w_issue    = 1'b1;
                    w_tmr_load = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_base      <= '0;
            r_rom_addr  <= '0;
            r_next_addr <= '0;
            r_len       <= '0;
            r_remain    <= '0;
            r_gap       <= '0;
            r_loop      <= 1'b0;
            r_done      <= 1'b0;
            r_data      <= '0;
        end else begin
            r_done <= w_finish || w_empty_start;
            if (w_launch) begin
                r_base     <= i_base;
                r_len      <= i_len;
                r_remain   <= i_len;
                r_loop     <= i_loop;
                r_gap      <= i_gap;
                r_rom_addr <= i_base;
            end
            if (w_capture) r_data <= i_rom_q;
            if (w_xfer) begin
                r_next_addr <= w_adv_addr;
                r_remain    <= w_last ? r_len : r_remain - 1'b1;
            end
            if (w_issue) r_rom_addr <= w_issue_addr;
        end
    end

    streamer_gap_cnt #(
        .W(TMR_W)
    ) u_wait_cnt (
        .clk       (clk),
        .rst       (rst),
        .i_load    (w_tmr_load),
        .i_load_val(w_tmr_val),
        .o_zero    (w_tmr_zero)
    );

    assign o_rom_addr = r_rom_addr;
    assign o_data     = r_data;
    assign o_vld      = (r_state == ST_SEND);
    assign o_busy     = (r_state != ST_IDLE);
    assign o_done     = r_done;

endmodule

// File: tb/tb_rom_uart_streamer.sv
// tb/tb_rom_uart_streamer.sv - directed table-driven bench for rom_uart_streamer
module tb_rom_uart_streamer;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_start;
    logic        i_abort;
    logic        i_loop;
    logic [9:0]  i_base;
    logic [10:0] i_len;
    logic [15:0] i_gap;
    logic [9:0]  o_rom_addr;
    logic [7:0]  rom_q;
    logic [7:0]  o_data;
    logic        o_vld;
    logic        i_rdy;
    logic        o_busy;
    logic        o_done;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic [9:0]  base;
        logic [10:0] len;
        logic [15:0] gap;
        int          stall_idx;
        int          stall_n;
        int          poke;
        int          exp_lat;
        int          exp_done;
    } vec_t;

    vec_t vecs[5];

    always #5 clk = ~clk;

    // ROM with one cycle of latency; contents are ROM[a] = a[7:0].
    always @(posedge clk) rom_q <= o_rom_addr[7:0];

    rom_uart_streamer #(
        .ADDR_W (10),
        .DATA_W (8),
        .ROM_LAT(1),
        .GAP_W  (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .i_start   (i_start),
        .i_abort   (i_abort),
        .i_loop    (i_loop),
        .i_base    (i_base),
        .i_len     (i_len),
        .i_gap     (i_gap),
        .o_rom_addr(o_rom_addr),
        .i_rom_q   (rom_q),
        .o_data    (o_data),
        .o_vld     (o_vld),
        .i_rdy     (i_rdy),
        .o_busy    (o_busy),
        .o_done    (o_done)
    );

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v);
        int         cyc = 0;
        int         k = 0;
        int         xfer_cyc = 0;
        int         ndone = 0;
        int         stalled = 0;
        bit         seen_vld = 1'b0;
        bit         fin = 1'b0;
        logic [9:0] prev_addr;
        logic [9:0] exp_addr;
        @(negedge clk);
        i_base  = v.base;
        i_len   = v.len;
        i_gap   = v.gap;
        i_loop  = 1'b0;
        i_rdy   = 1'b1;
        i_start = 1'b1;
        prev_addr = o_rom_addr;
        while (!fin) begin
            @(negedge clk);
            cyc++;
            i_start = 1'b0;
            if (v.poke != 0 && (cyc == 2 || cyc == 5)) begin
                i_start = 1'b1;
                i_base  = 10'd50;
                i_len   = 11'd7;
                i_gap   = 16'd3;
            end
            chk("busy", int'(o_busy), (k < int'(v.len)) ? 1 : 0);
            if (cyc == 1 && v.len != 0) chk("first_addr", int'(o_rom_addr), int'(v.base));
            if (o_rom_addr != prev_addr && k > 0) chk("addr_gap", cyc - xfer_cyc, int'(v.gap) + 1);
            prev_addr = o_rom_addr;
            if (k == int'(v.len)) chk("vld_low", int'(o_vld), 0);
            if (o_vld && !seen_vld) begin
                seen_vld = 1'b1;
                chk("first_vld", cyc, v.exp_lat);
            end
            if (o_done) begin
                ndone++;
                chk("done_time", cyc, xfer_cyc + 1);
                chk("done_count", k, int'(v.len));
            end
            i_rdy = 1'b1;
            exp_addr = v.base + 10'(k);
            if (o_vld && k == v.stall_idx && stalled < v.stall_n) begin
                stalled++;
                i_rdy = 1'b0;
                chk("stall_data", int'(o_data), int'(exp_addr[7:0]));
            end
            if (o_vld && i_rdy) begin
                chk("xfer_addr", int'(o_rom_addr), int'(exp_addr));
                chk("xfer_data", int'(o_data), int'(exp_addr[7:0]));
                k++;
                xfer_cyc = cyc;
            end
            if (k == int'(v.len) && cyc > xfer_cyc + 1) fin = 1'b1;
            if (!fin && cyc > 300) begin
                n_vec++;
                n_bad++;
                $display("FAIL timeout: stream base=%0d len=%0d not finished after %0d cycles", v.base, v.len, cyc);
                fin = 1'b1;
            end
        end
        i_rdy = 1'b1;
        chk("done_pulses", ndone, v.exp_done);
    endtask

    initial begin
        int  k;
        bit  ab;
        vec_t pv;
        rst     = 1'b1;
        i_start = 1'b0;
        i_abort = 1'b0;
        i_loop  = 1'b0;
        i_base  = '0;
        i_len   = '0;
        i_gap   = '0;
        i_rdy   = 1'b1;

        vecs[0] = '{base: 10'd5,    len: 11'd3, gap: 16'd0,  stall_idx: -1, stall_n: 0, poke: 0, exp_lat: 3, exp_done: 1};
        vecs[1] = '{base: 10'd1022, len: 11'd4, gap: 16'd0,  stall_idx: -1, stall_n: 0, poke: 0, exp_lat: 3, exp_done: 1};
        vecs[2] = '{base: 10'd0,    len: 11'd0, gap: 16'd0,  stall_idx: -1, stall_n: 0, poke: 0, exp_lat: 3, exp_done: 1};
        vecs[3] = '{base: 10'd20,   len: 11'd3, gap: 16'd10, stall_idx: 1,  stall_n: 7, poke: 0, exp_lat: 3, exp_done: 1};
        vecs[4] = '{base: 10'd100,  len: 11'd2, gap: 16'd1,  stall_idx: 0,  stall_n: 2, poke: 0, exp_lat: 3, exp_done: 1};

        repeat (3) @(negedge clk);
        chk("rst_addr", int'(o_rom_addr), 0);
        chk("rst_data", int'(o_data), 0);
        chk("rst_vld", int'(o_vld), 0);
        chk("rst_busy", int'(o_busy), 0);
        chk("rst_done", int'(o_done), 0);
        rst = 1'b0;

        for (int i = 0; i < 5; i++) run_vec(vecs[i]);

        // Loop mode, then abort coinciding with a transfer.
        @(negedge clk);
        i_base  = 10'd0;
        i_len   = 11'd2;
        i_gap   = 16'd0;
        i_loop  = 1'b1;
        i_rdy   = 1'b1;
        i_start = 1'b1;
        k  = 0;
        ab = 1'b0;
        for (int c = 1; c <= 60 && !ab; c++) begin
            @(negedge clk);
            i_start = 1'b0;
            chk("loop_no_done", int'(o_done), 0);
            if (o_vld) begin
                chk("loop_data", int'(o_data), k % 2);
                if (k == 5) begin
                    i_abort = 1'b1;
                    ab = 1'b1;
                end
                k++;
            end
        end
        if (!ab) begin
            n_vec++;
            n_bad++;
            $display("FAIL loop_timeout: only %0d bytes seen", k);
        end
        @(negedge clk);
        i_abort = 1'b0;
        i_loop  = 1'b0;
        chk("abort_vld", int'(o_vld), 0);
        chk("abort_busy", int'(o_busy), 0);
        chk("abort_done", int'(o_done), 0);
        @(negedge clk);
        chk("abort_done_late", int'(o_done), 0);
        chk("abort_idle", int'(o_busy), 0);

        // Reset while in FETCH.
        @(negedge clk);
        i_base  = 10'd7;
        i_len   = 11'd3;
        i_gap   = 16'd0;
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        chk("pre_rst_busy", int'(o_busy), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_addr", int'(o_rom_addr), 0);
        chk("mid_rst_data", int'(o_data), 0);
        chk("mid_rst_vld", int'(o_vld), 0);
        chk("mid_rst_busy", int'(o_busy), 0);
        chk("mid_rst_done", int'(o_done), 0);
        @(negedge clk);
        chk("post_rst_done", int'(o_done), 0);
        chk("post_rst_busy", int'(o_busy), 0);

        // Fresh stream with start pulses and input changes while busy.
        pv = '{base: 10'd9, len: 11'd3, gap: 16'd0, stall_idx: -1, stall_n: 0, poke: 1, exp_lat: 3, exp_done: 1};
        run_vec(pv);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
